// File: rtl/tpu_pkg.sv
// Shared TPU types: address widths, MMU instruction bundle
// and the MMU control FSM state encoding.
package tpu_pkg;

    localparam int BUFFER_ADDRESS_WIDTH      = 24;
    localparam int ACCUMULATOR_ADDRESS_WIDTH = 16;
    localparam int LENGTH_WIDTH              = 16;

    typedef struct packed {
        logic [BUFFER_ADDRESS_WIDTH-1:0]      buf_addr;
        logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr;
        logic [LENGTH_WIDTH-1:0]              length;
        logic                                 accumulate;
        logic                                 systolic_signed;
        logic                                 activate_weight;
    } mmu_instr_type;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_WEIGHT = 2'd1,
        STREAM      = 2'd2,
        DRAIN       = 2'd3
    } mmu_ctrl_state_type;

endpackage

// File: rtl/control_delay_line.sv
// Fixed-depth shift register with synchronous active-low flush.
// Ports: clk, rst (0 = flush), din, dout (DEPTH cycles later),
// pending (MSB valid bit set in any stage except the output one).
module control_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             pending
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    // The output stage is excluded so the owner can retire
    // on the same cycle the final entry is presented.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) begin
            pending = pending | stage[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/matrix_multiply_control.sv
// Sequences the systolic MMU for one instruction at a time.
// Ports: instr handshake, weight_ready/weight_consume, buffer
// read (buf_rd_*), MMU controls (mmu_*), accumulator write
// (acc_*) delayed RESULT_LATENCY cycles per row, and busy.
module matrix_multiply_control
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH   = 14,
    parameter int RESULT_LATENCY = 2*MATRIX_WIDTH+2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 instr_valid,
    output logic                                 instr_ready,
    input  mmu_instr_type                        instr,
    input  logic                                 weight_ready,
    output logic                                 weight_consume,
    output logic [BUFFER_ADDRESS_WIDTH-1:0]      buf_rd_addr,
    output logic                                 buf_rd_en,
    output logic                                 mmu_enable,
    output logic                                 mmu_activate_weight,
    output logic                                 mmu_systolic_signed,
    output logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_wr_addr,
    output logic                                 acc_wr_en,
    output logic                                 acc_accumulate,
    output logic                                 busy
);

    localparam int DW = ACCUMULATOR_ADDRESS_WIDTH + 2;

    mmu_ctrl_state_type state, state_nx;
    mmu_instr_type      instr_q, cur;

    logic [LENGTH_WIDTH-1:0]              cnt, row;
    logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_row;
    logic accum_row, signed_row, act_row;
    logic accept, go, start, issue, last;
    logic pending, drain_done;
    logic [DW-1:0] dl_in, dl_out;

    assign instr_ready = (state == IDLE) || (state == DRAIN);
    assign accept      = instr_valid && instr_ready;
    assign drain_done  = !buf_rd_en && !pending;

    // Row 0 is registered on the accepting edge, so an instruction
    // taken in DRAIN streams with no gap after the previous one.
    always_comb begin
        cur      = accept ? instr : instr_q;
        go       = accept && (instr.length != '0);
        start    = go && (!instr.activate_weight || weight_ready);
        issue    = 1'b0;
        row      = cnt;
        state_nx = state;
        unique case (state)
            IDLE, DRAIN: begin
                if (go) begin
                    issue    = start;
                    row      = '0;
                    state_nx = start ? STREAM : WAIT_WEIGHT;
                end else if (state == DRAIN && drain_done) begin
                    state_nx = IDLE;
                end
            end
            WAIT_WEIGHT: begin
                if (weight_ready) begin
                    issue    = 1'b1;
                    row      = '0;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                issue = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        last = (row == cur.length - 16'd1);
        if (issue && last) begin
            state_nx = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= IDLE;
            instr_q             <= '0;
            cnt                 <= '0;
            buf_rd_en           <= 1'b0;
            buf_rd_addr         <= '0;
            acc_row             <= '0;
            accum_row           <= 1'b0;
            signed_row          <= 1'b0;
            act_row             <= 1'b0;
            mmu_activate_weight <= 1'b0;
            mmu_systolic_signed <= 1'b0;
        end else begin
            state     <= state_nx;
            buf_rd_en <= issue;
            mmu_activate_weight <= buf_rd_en && act_row;
            mmu_systolic_signed <= buf_rd_en && signed_row;
            if (accept) begin
                instr_q <= instr;
            end
            if (issue) begin
                cnt         <= row + 16'd1;
                buf_rd_addr <= cur.buf_addr
                             + BUFFER_ADDRESS_WIDTH'(row);
                acc_row     <= cur.acc_addr + row;
                accum_row   <= cur.accumulate;
                signed_row  <= cur.systolic_signed;
                act_row     <= cur.activate_weight && (row == '0);
            end
        end
    end

    assign weight_consume = mmu_activate_weight;

    assign dl_in = {buf_rd_en,
                    buf_rd_en ? acc_row : '0,
                    buf_rd_en && accum_row};

    control_delay_line #(
        .WIDTH (DW),
        .DEPTH (RESULT_LATENCY)
    ) u_result_dl (
        .clk     (clk),
        .rst     (rst),
        .din     (dl_in),
        .dout    (dl_out),
        .pending (pending)
    );

    assign acc_wr_en      = dl_out[DW-1];
    assign acc_wr_addr    = dl_out[DW-2:1];
    assign acc_accumulate = dl_out[0];

    assign busy       = (state != IDLE) || buf_rd_en
                      || pending || acc_wr_en;
    assign mmu_enable = busy;

endmodule

// File: tb/tb_matrix_multiply_control.sv
// Directed bench for matrix_multiply_control, MATRIX_WIDTH=4.
// Cycle k is the interval after the k-th edge past acceptance.
module tb_matrix_multiply_control;
    import tpu_pkg::*;

    localparam int MW = 4;
    localparam int RL = 2*MW+2;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    mmu_instr_type instr;
    logic          weight_ready;
    logic          weight_consume;
    logic [23:0]   buf_rd_addr;
    logic          buf_rd_en;
    logic          mmu_enable;
    logic          mmu_activate_weight;
    logic          mmu_systolic_signed;
    logic [15:0]   acc_wr_addr;
    logic          acc_wr_en;
    logic          acc_accumulate;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matrix_multiply_control #(
        .MATRIX_WIDTH   (MW),
        .RESULT_LATENCY (RL)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr               (instr),
        .weight_ready        (weight_ready),
        .weight_consume      (weight_consume),
        .buf_rd_addr         (buf_rd_addr),
        .buf_rd_en           (buf_rd_en),
        .mmu_enable          (mmu_enable),
        .mmu_activate_weight (mmu_activate_weight),
        .mmu_systolic_signed (mmu_systolic_signed),
        .acc_wr_addr         (acc_wr_addr),
        .acc_wr_en           (acc_wr_en),
        .acc_accumulate      (acc_accumulate),
        .busy                (busy)
    );

    function automatic mmu_instr_type mk(
        input logic [23:0] b, input logic [15:0] a,
        input logic [15:0] n, input logic acc,
        input logic sg, input logic act);
        mmu_instr_type t;
        t.buf_addr        = b;
        t.acc_addr        = a;
        t.length          = n;
        t.accumulate      = acc;
        t.systolic_signed = sg;
        t.activate_weight = act;
        return t;
    endfunction

    task automatic offer(input mmu_instr_type t);
        instr       = t;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({buf_rd_en, buf_rd_addr, mmu_enable, busy,
             mmu_activate_weight, mmu_systolic_signed,
             weight_consume, acc_wr_en, acc_wr_addr,
             acc_accumulate} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got nonzero rd=%b en=%b busy=%b",
                     buf_rd_en, mmu_enable, busy);
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
        rst = 1'b1;
        offer(mk(24'h30, 16'h40, 16'd8, 1'b0, 1'b1, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({buf_rd_en, buf_rd_addr, mmu_enable, busy,
             mmu_activate_weight, mmu_systolic_signed,
             weight_consume, acc_wr_en, acc_wr_addr,
             acc_accumulate} !== '0) begin
            errors++;
            $display("FAIL midreset_outs: got rd=%b en=%b busy=%b",
                     buf_rd_en, mmu_enable, busy);
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b want 1", instr_ready);
        end
        rst  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2*RL; k++) begin
            if (acc_wr_en !== 1'b0 || buf_rd_en !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: activity=%b want 0", seen);
        end
    endtask

    task automatic test_basic();
        logic e_rd, e_wr, e_busy, e_sg, e_rdy;
        offer(mk(24'h10, 16'h5, 16'd3, 1'b0, 1'b1, 1'b0));
        for (int k = 1; k <= 16; k++) begin
            e_rd   = (k >= 1 && k <= 3);
            e_wr   = (k >= 11 && k <= 13);
            e_busy = (k <= 13);
            e_sg   = (k >= 2 && k <= 4);
            e_rdy  = (k >= 3);
            checks++;
            if (buf_rd_en !== e_rd) begin
                errors++;
                $display("FAIL basic_rd_en c%0d: got %b want %b",
                         k, buf_rd_en, e_rd);
            end
            if (e_rd) begin
                checks++;
                if (buf_rd_addr !== 24'(24'h10 + k - 1)) begin
                    errors++;
                    $display("FAIL basic_rd_addr c%0d: got %h want %h",
                             k, buf_rd_addr, 24'(24'h10 + k - 1));
                end
            end
            checks++;
            if (acc_wr_en !== e_wr) begin
                errors++;
                $display("FAIL basic_wr_en c%0d: got %b want %b",
                         k, acc_wr_en, e_wr);
            end
            if (e_wr) begin
                checks++;
                if (acc_wr_addr !== 16'(5 + k - 11)
                    || acc_accumulate !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_wr_addr c%0d: got %h/%b want %h/0",
                             k, acc_wr_addr, acc_accumulate,
                             16'(5 + k - 11));
                end
            end
            checks++;
            if (busy !== e_busy || mmu_enable !== e_busy) begin
                errors++;
                $display("FAIL basic_busy c%0d: got %b/%b want %b",
                         k, busy, mmu_enable, e_busy);
            end
            checks++;
            if (mmu_systolic_signed !== e_sg) begin
                errors++;
                $display("FAIL basic_signed c%0d: got %b want %b",
                         k, mmu_systolic_signed, e_sg);
            end
            checks++;
            if (instr_ready !== e_rdy) begin
                errors++;
                $display("FAIL basic_ready c%0d: got %b want %b",
                         k, instr_ready, e_rdy);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wait_weight();
        logic e_rd, e_act, e_wr;
        weight_ready = 1'b0;
        offer(mk(24'h100, 16'h20, 16'd2, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k <= 20; k++) begin
            e_rd  = (k == 7 || k == 8);
            e_act = (k == 8);
            e_wr  = (k == 17 || k == 18);
            checks++;
            if (buf_rd_en !== e_rd) begin
                errors++;
                $display("FAIL wait_rd_en c%0d: got %b want %b",
                         k, buf_rd_en, e_rd);
            end
            if (e_rd) begin
                checks++;
                if (buf_rd_addr !== 24'(24'h100 + k - 7)) begin
                    errors++;
                    $display("FAIL wait_rd_addr c%0d: got %h want %h",
                             k, buf_rd_addr, 24'(24'h100 + k - 7));
                end
            end
            checks++;
            if (mmu_activate_weight !== e_act
                || weight_consume !== e_act) begin
                errors++;
                $display("FAIL wait_activate c%0d: got %b/%b want %b",
                         k, mmu_activate_weight, weight_consume, e_act);
            end
            checks++;
            if (acc_wr_en !== e_wr) begin
                errors++;
                $display("FAIL wait_wr_en c%0d: got %b want %b",
                         k, acc_wr_en, e_wr);
            end
            if (k <= 6) begin
                checks++;
                if (instr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_ready c%0d: got %b want 0",
                             k, instr_ready);
                end
            end
            if (k == 6) weight_ready = 1'b1;
            if (k == 9) weight_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic        e_rd, e_wr, e_acc;
        logic [23:0] e_ra;
        logic [15:0] e_wa;
        int          j;
        offer(mk(24'h40, 16'h80, 16'd2, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 18; k++) begin
            e_rd  = (k >= 1 && k <= 5);
            e_ra  = (k <= 2) ? 24'(24'h40 + k - 1)
                             : 24'(24'h200 + k - 3);
            j     = k - 10;
            e_wr  = (j >= 1 && j <= 5);
            e_wa  = (j <= 2) ? 16'(16'h80 + j - 1)
                             : 16'(16'h90 + j - 3);
            e_acc = (j > 2);
            checks++;
            if (buf_rd_en !== e_rd) begin
                errors++;
                $display("FAIL b2b_rd_en c%0d: got %b want %b",
                         k, buf_rd_en, e_rd);
            end
            if (e_rd) begin
                checks++;
                if (buf_rd_addr !== e_ra) begin
                    errors++;
                    $display("FAIL b2b_rd_addr c%0d: got %h want %h",
                             k, buf_rd_addr, e_ra);
                end
            end
            checks++;
            if (acc_wr_en !== e_wr) begin
                errors++;
                $display("FAIL b2b_wr_en c%0d: got %b want %b",
                         k, acc_wr_en, e_wr);
            end
            if (e_wr) begin
                checks++;
                if (acc_wr_addr !== e_wa || acc_accumulate !== e_acc) begin
                    errors++;
                    $display("FAIL b2b_wr c%0d: got %h/%b want %h/%b",
                             k, acc_wr_addr, acc_accumulate, e_wa, e_acc);
                end
            end
            if (k == 2) begin
                checks++;
                if (instr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_drain: got %b want 1",
                             instr_ready);
                end
                instr = mk(24'h200, 16'h90, 16'd3, 1'b1, 1'b0, 1'b0);
                instr_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_wrap();
        logic e_rd, e_wr;
        offer(mk(24'hFFFFFF, 16'hFFFF, 16'd2, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 14; k++) begin
            e_rd = (k == 1 || k == 2);
            e_wr = (k == 11 || k == 12);
            checks++;
            if (buf_rd_en !== e_rd) begin
                errors++;
                $display("FAIL wrap_rd_en c%0d: got %b want %b",
                         k, buf_rd_en, e_rd);
            end
            if (e_rd) begin
                checks++;
                if (buf_rd_addr !== (k == 1 ? 24'hFFFFFF : 24'h000000)) begin
                    errors++;
                    $display("FAIL wrap_rd_addr c%0d: got %h", k, buf_rd_addr);
                end
            end
            checks++;
            if (acc_wr_en !== e_wr) begin
                errors++;
                $display("FAIL wrap_wr_en c%0d: got %b want %b",
                         k, acc_wr_en, e_wr);
            end
            if (e_wr) begin
                checks++;
                if (acc_wr_addr !== (k == 11 ? 16'hFFFF : 16'h0000)) begin
                    errors++;
                    $display("FAIL wrap_wr_addr c%0d: got %h", k, acc_wr_addr);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_zero_length();
        weight_ready = 1'b1;
        offer(mk(24'h55, 16'h66, 16'd0, 1'b1, 1'b1, 1'b1));
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (buf_rd_en !== 1'b0 || mmu_activate_weight !== 1'b0
                || weight_consume !== 1'b0 || busy !== 1'b0
                || instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL zero_len c%0d: rd=%b act=%b cons=%b busy=%b rdy=%b",
                         k, buf_rd_en, mmu_activate_weight,
                         weight_consume, busy, instr_ready);
            end
            @(posedge clk);
            #1;
        end
        weight_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        instr_valid  = 1'b0;
        instr        = '0;
        weight_ready = 1'b0;
        test_reset();
        test_basic();
        test_wait_weight();
        test_back_to_back();
        test_wrap();
        test_zero_length();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_multiply_control.md
Name: matrix_multiply_control

Overview:
Sequences the matrix_multiply_unit for one MMU instruction at a time. It accepts an instruction over a valid/ready handshake and issues unified-buffer read addresses for each input row. It drives the MMU enable, activate_weight and systolic_signed controls, and produces delayed accumulator write address/enable aligned to each result row. It sits between the instruction decoder, the weight controller, the unified buffer and the accumulator array.

Parameters:
MATRIX_WIDTH, 14, systolic array dimension.
RESULT_LATENCY, 2*MATRIX_WIDTH+2, cycles from a row's buf_rd_en to that row's acc_wr_en.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
instr_valid  in  1  instruction offered
instr_ready  out  1  instruction accepted when valid&ready
instr  in  mmu_instr_type  {buf_addr[23:0], acc_addr[15:0], length[15:0], accumulate, systolic_signed, activate_weight}
weight_ready  in  1  weight controller has a fully preloaded weight set
weight_consume  out  1  one-cycle pulse: preloaded set taken into use
buf_rd_addr  out  24  unified buffer read address
buf_rd_en  out  1  unified buffer read strobe; data returns next cycle
mmu_enable  out  1  MMU enable
mmu_activate_weight  out  1  to MMU activate_weight
mmu_systolic_signed  out  1  to MMU systolic_signed
acc_wr_addr  out  16  accumulator row address
acc_wr_en  out  1  accumulator write strobe
acc_accumulate  out  1  1 = add to stored value, 0 = overwrite
busy  out  1  FSM not IDLE or delay line non-empty

Behaviour:
- Reset (rst=0 at a clock edge): FSM to IDLE, counters cleared, delay line flushed. All outputs 0 except instr_ready=1. Reset mid-instruction drops in-flight rows; no acc_wr_en is issued after reset.
- FSM states: IDLE, WAIT_WEIGHT, STREAM, DRAIN.
- instr_ready=1 in IDLE and DRAIN, 0 in WAIT_WEIGHT and STREAM.
- Accept when instr_valid & instr_ready. The instruction fields are latched.
  - length==0: no-op. No reads, no activation, no consume. State stays or returns to IDLE/DRAIN as appropriate.
  - activate_weight=1 and weight_ready=0: go to WAIT_WEIGHT.
  - Otherwise: go to STREAM.
- WAIT_WEIGHT: remain until weight_ready=1, then go to STREAM.
- STREAM issues one read per cycle, rows r = 0..length-1:
  - buf_rd_en=1, buf_rd_addr = latched buf_addr + r.
  - buf_rd_addr wraps modulo 2^24.
  - Leave STREAM after row length-1: go to DRAIN.
  - Back-to-back: an instruction accepted in DRAIN goes directly to STREAM/WAIT_WEIGHT. The next instruction's row 0 follows the previous instruction's last row with zero bubble.
- Weight activation (activate_weight=1):
  - mmu_activate_weight=1 for exactly one cycle: the cycle after row 0's buf_rd_en, aligned with row 0 data at the MMU input.
  - weight_consume pulses in that same cycle.
- mmu_systolic_signed equals the latched systolic_signed, delayed 1 cycle relative to buf_rd_en, for every row.
- Result delay line, depth RESULT_LATENCY:
  - Carries {valid, acc_addr + r, accumulate} per row.
  - Output appears on acc_wr_en/acc_wr_addr/acc_accumulate exactly RESULT_LATENCY cycles after that row's buf_rd_en.
  - acc_wr_addr wraps modulo 2^16.
- DRAIN: wait until the delay line is empty, then go to IDLE.
- mmu_enable=1 whenever busy=1. It is 0 only in IDLE with an empty delay line.
- Row counter is 16-bit; length up to 65535.

Decomposition:
- tpu_pkg gains:
  - BUFFER_ADDRESS_WIDTH=24, ACCUMULATOR_ADDRESS_WIDTH=16, LENGTH_WIDTH=16.
  - Packed struct mmu_instr_type.
  - Enum mmu_ctrl_state_type {IDLE, WAIT_WEIGHT, STREAM, DRAIN}.
- One sub-module, control_delay_line #(WIDTH, DEPTH): synchronous active-low-reset shift register used for the result delay line.

Test Plan:
- Reset: hold rst=0 for 3 cycles during STREAM -> all outputs 0, instr_ready=1, and no acc_wr_en for the following 2*RESULT_LATENCY cycles.
- MATRIX_WIDTH=4 (RESULT_LATENCY=10): instr buf_addr=0x10, acc_addr=0x5, length=3, activate=0 at cycle 0 -> buf_rd_en cycles 1-3 with addr 0x10..0x12; acc_wr_en cycles 11-13 with addr 5..7; busy falls at cycle 14.
- Activate with weight_ready=0: instr activate=1, weight_ready raised at cycle 6 -> no reads before cycle 7. mmu_activate_weight and weight_consume pulse once, one cycle after the first read.
- Back-to-back: second instr offered while first is in DRAIN -> accepted immediately, zero-gap reads. acc_accumulate follows each instruction's flag per row.
- Wrap: buf_addr=0xFFFFFF, acc_addr=0xFFFF, length=2 -> read addrs 0xFFFFFF, 0x000000; write addrs 0xFFFF, 0x0000.
- length=0 with activate=1 -> accepted, no reads, no activation, no consume, busy stays 0.
